boot_rom_arbiter: RTL and testbench
===================================

// Module: boot_rom_arbiter
// PURPOSE
//  Shares the single-ported synchronous boot ROM between the core instruction
//  port (P0) and the data/debug port (P1) using the req/gnt/rvalid protocol.
//  Round-robin arbitration; one access per cycle; fixed 1-cycle read latency.
//  Blocks writes and out-of-window accesses and answers them with an error.
//  Sits between the core-side interconnect ports and the boot ROM wrapper.
// PARAMETERS
//  ADDR_WIDTH  12           byte-address width of ROM window (4 KiB)
//  DATA_WIDTH  32           ROM word width
//  ROM_BASE    32'h0000_8000  window base; match on addr[31:ADDR_WIDTH]
// PORTS
//  clk            in   1           single clock; all state on rising edge
//  rst            in   1           synchronous reset, active-high
//  p0_req_i       in   1           P0 (instr) request
//  p0_addr_i      in   32          P0 byte address
//  p0_gnt_o       out  1           P0 grant (combinational)
//  p0_rvalid_o    out  1           P0 response valid
//  p0_rdata_o     out  DATA_WIDTH  P0 read data
//  p0_err_o       out  1           P0 error; valid with p0_rvalid_o
//  p1_req_i       in   1           P1 (data/debug) request
//  p1_we_i        in   1           P1 write enable
//  p1_addr_i      in   32          P1 byte address
//  p1_gnt_o       out  1           P1 grant (combinational)
//  p1_rvalid_o    out  1           P1 response valid
//  p1_rdata_o     out  DATA_WIDTH  P1 read data
//  p1_err_o       out  1           P1 error; valid with p1_rvalid_o
//  rom_en_o       out  1           ROM enable
//  rom_addr_o     out  ADDR_WIDTH  ROM byte address (ROM uses [ADDR_WIDTH-1:2])
//  rom_rdata_i    in   DATA_WIDTH  ROM data, valid 1 cycle after rom_en_o
// BEHAVIOUR
//  - Reset (rst=1 at edge): rr_last<=P1 (P0 wins first tie), resp_valid<=0,
//    resp_owner<=P0, resp_err<=0. During/after reset: all rvalid/err=0,
//    rdata=0, rom_en_o=0. Request in the reset cycle: no gnt.
//  - Arbitration (comb): only one req -> grant it. Both -> grant port !=
//    rr_last. rr_last updates to the granted port on each grant. Exactly
//    zero or one gnt high per cycle.
//  - Legal access: granted, addr[31:ADDR_WIDTH]==ROM_BASE[31:ADDR_WIDTH] and,
//    for P1, we_i=0. Then rom_en_o=1, rom_addr_o=addr[ADDR_WIDTH-1:0] same cycle.
//  - Illegal access (P1 write or address out of window): still granted,
//    rom_en_o=0; next cycle rvalid=1, err=1, rdata=0.
//  - Response: grant at cycle t -> rvalid for that port exactly at t+1,
//    rdata=rom_rdata_i (legal) combinational pass-through, err=0. Never
//    rvalid on the non-owner port. rdata=0 when rvalid=0.
//  - Throughput: back-to-back grants every cycle; grant at t+1 overlaps
//    response of t. Alternates P0/P1 under continuous dual request.
//  - No outstanding-limit stalls: requester must accept rvalid (no ready).
//  - req dropped without gnt: no state change. addr sampled only at gnt.
//  - Reset mid-operation: pending response discarded (rvalid not issued).
//  - Unaligned addr: low 2 bits ignored (word read), no error.
// TESTING
//  1 P0 req addr 0x8000 at t -> p0_gnt t, rom_en/rom_addr=0x000 t, p0_rvalid t+1
//    with rom word 0; p1 outputs stay 0.
//  2 P0+P1 req continuously 6 cycles after reset -> grants P0,P1,P0,P1,P0,P1;
//    each rvalid one cycle later on matching port only.
//  3 P1 we=1 addr 0x8004 -> p1_gnt, rom_en_o=0, next cycle p1_rvalid=1,
//    p1_err=1, p1_rdata=0.
//  4 P0 addr 0x9000 (outside 4 KiB window) -> gnt, rom_en_o=0, rvalid+err next.
//  5 Grant at t, rst=1 at t+1 edge -> no rvalid at t+1; after release,
//    P0+P1 tie grants P0 first.
//  6 Random req/addr 10k cycles vs scoreboard ROM model -> every gnt has one
//    rvalid 1 cycle later, data/err match, never two gnts per cycle.

Source files
------------

// File: rtl/boot_rom_arbiter_if.sv
// Boot ROM arbiter bus bundle: two requester ports (P0 instruction, P1
// data/debug) using req/gnt/rvalid, plus the synchronous boot ROM side.
//   slave  : arbiter view (takes requests and ROM data, drives grants,
//            responses and the ROM enable/address)
//   master : requester/ROM view (mirror of slave)
interface boot_rom_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  p0_req_i;
    logic [31:0]           p0_addr_i;
    logic                  p0_gnt_o;
    logic                  p0_rvalid_o;
    logic [DATA_WIDTH-1:0] p0_rdata_o;
    logic                  p0_err_o;

    logic                  p1_req_i;
    logic                  p1_we_i;
    logic [31:0]           p1_addr_i;
    logic                  p1_gnt_o;
    logic                  p1_rvalid_o;
    logic [DATA_WIDTH-1:0] p1_rdata_o;
    logic                  p1_err_o;

    logic                  rom_en_o;
    logic [ADDR_WIDTH-1:0] rom_addr_o;
    logic [DATA_WIDTH-1:0] rom_rdata_i;

    modport slave (
        input  p0_req_i, p0_addr_i,
        input  p1_req_i, p1_we_i, p1_addr_i,
        input  rom_rdata_i,
        output p0_gnt_o, p0_rvalid_o, p0_rdata_o, p0_err_o,
        output p1_gnt_o, p1_rvalid_o, p1_rdata_o, p1_err_o,
        output rom_en_o, rom_addr_o
    );

    modport master (
        output p0_req_i, p0_addr_i,
        output p1_req_i, p1_we_i, p1_addr_i,
        output rom_rdata_i,
        input  p0_gnt_o, p0_rvalid_o, p0_rdata_o, p0_err_o,
        input  p1_gnt_o, p1_rvalid_o, p1_rdata_o, p1_err_o,
        input  rom_en_o, rom_addr_o
    );
endinterface

// File: rtl/boot_rom_arbiter.sv
// Boot ROM arbiter: shares a single-ported synchronous boot ROM between the
// core instruction port (P0) and the data/debug port (P1). Round-robin,
// one access per cycle, fixed one-cycle read latency. P1 writes and
// out-of-window accesses are granted but answered with an error.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous reset, active-high
//   bus  - boot_rom_arbiter_if.slave (P0/P1 req/gnt/rvalid, ROM en/addr/data)
module boot_rom_arbiter #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] ROM_BASE   = 32'h0000_8000
) (
    input  logic                     clk,
    input  logic                     rst,
    boot_rom_arbiter_if.slave        bus
);
    localparam int unsigned TAG_WIDTH = 32 - ADDR_WIDTH;
    localparam logic [TAG_WIDTH-1:0] ROM_TAG = ROM_BASE[31:ADDR_WIDTH];

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    port_e       rr_last_q,    rr_last_d;
    port_e       resp_owner_q, resp_owner_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q,   resp_err_d;

    logic        gnt0;
    logic        gnt1;
    logic        gnt_any;
    port_e       gnt_port;
    logic [31:0] gnt_addr;
    logic        gnt_legal;
    logic        resp_live;

    // Arbitration: a tie goes to the port that was not granted last.
    // Nothing is granted while reset is asserted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (bus.p0_req_i && bus.p1_req_i) begin
                if (rr_last_q == PORT1) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else begin
                gnt0 = bus.p0_req_i;
                gnt1 = bus.p1_req_i;
            end
        end
        gnt_any   = gnt0 | gnt1;
        gnt_port  = gnt1 ? PORT1 : PORT0;
        gnt_addr  = gnt1 ? bus.p1_addr_i : bus.p0_addr_i;
        gnt_legal = (gnt_addr[31:ADDR_WIDTH] == ROM_TAG) && !(gnt1 && bus.p1_we_i);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_q    <= PORT1;
            resp_valid_q <= 1'b0;
            resp_owner_q <= PORT0;
            resp_err_q   <= 1'b0;
        end else begin
            rr_last_q    <= rr_last_d;
            resp_valid_q <= resp_valid_d;
            resp_owner_q <= resp_owner_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Next state: every grant schedules exactly one response next cycle.
    always_comb begin
        rr_last_d    = rr_last_q;
        resp_valid_d = 1'b0;
        resp_owner_d = resp_owner_q;
        resp_err_d   = 1'b0;
        if (gnt_any) begin
            rr_last_d    = gnt_port;
            resp_valid_d = 1'b1;
            resp_owner_d = gnt_port;
            resp_err_d   = !gnt_legal;
        end
    end

    // Grant and ROM access in the request cycle.
    always_comb begin
        bus.p0_gnt_o   = gnt0;
        bus.p1_gnt_o   = gnt1;
        bus.rom_en_o   = gnt_any && gnt_legal;
        bus.rom_addr_o = bus.rom_en_o ? gnt_addr[ADDR_WIDTH-1:0] : ADDR_WIDTH'(0);
    end

    // Response steering; ROM data passes straight through on a legal read.
    // Asserting reset suppresses a pending response immediately.
    always_comb begin
        resp_live       = resp_valid_q && !rst;
        bus.p0_rvalid_o = resp_live && (resp_owner_q == PORT0);
        bus.p1_rvalid_o = resp_live && (resp_owner_q == PORT1);
        bus.p0_err_o    = bus.p0_rvalid_o && resp_err_q;
        bus.p1_err_o    = bus.p1_rvalid_o && resp_err_q;
        bus.p0_rdata_o  = (bus.p0_rvalid_o && !resp_err_q) ? bus.rom_rdata_i : DATA_WIDTH'(0);
        bus.p1_rdata_o  = (bus.p1_rvalid_o && !resp_err_q) ? bus.rom_rdata_i : DATA_WIDTH'(0);
    end
endmodule

// File: tb/tb_boot_rom_arbiter.sv
// Testbench for boot_rom_arbiter: behavioural synchronous ROM, reference
// arbitration model and a response scoreboard.
module tb_boot_rom_arbiter;
    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    boot_rom_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    boot_rom_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .ROM_BASE  (32'h0000_8000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ROM contents as a function of word index.
    function automatic logic [31:0] rom_word(input logic [9:0] w);
        return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    logic [DW-1:0] rom_q = '0;
    always @(posedge clk) begin
        if (bus.rom_en_o) rom_q <= rom_word(bus.rom_addr_o[AW-1:2]);
    end
    assign bus.rom_rdata_i = rom_q;

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    logic rr_m = 1'b1;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive, check responses and grants at negedge,
    // update the reference model after the edge.
    task automatic cycle(input logic r, input logic q0, input logic [31:0] a0,
                         input logic q1, input logic w1, input logic [31:0] a1);
        exp_t        e;
        logic        has;
        logic        g0;
        logic        g1;
        logic        legal;
        logic [31:0] ga;
        rst           = r;
        bus.p0_req_i  = q0;
        bus.p0_addr_i = a0;
        bus.p1_req_i  = q1;
        bus.p1_we_i   = w1;
        bus.p1_addr_i = a1;
        @(negedge clk);

        has = 1'b0;
        e   = '{port: 1'b0, err: 1'b0, data: 32'h0};
        if (r) begin
            sb.delete();
        end else if (sb.size() > 0) begin
            e   = sb.pop_front();
            has = 1'b1;
        end
        chk("p0_rvalid", bus.p0_rvalid_o, has && !e.port);
        chk("p1_rvalid", bus.p1_rvalid_o, has && e.port);
        chk("p0_err", bus.p0_err_o, has && !e.port && e.err);
        chk("p1_err", bus.p1_err_o, has && e.port && e.err);
        chk("p0_rdata", bus.p0_rdata_o, (has && !e.port) ? e.data : 32'h0);
        chk("p1_rdata", bus.p1_rdata_o, (has && e.port) ? e.data : 32'h0);

        g0 = 1'b0;
        g1 = 1'b0;
        if (!r) begin
            if (q0 && q1) begin
                g0 = rr_m;
                g1 = !rr_m;
            end else begin
                g0 = q0;
                g1 = q1;
            end
        end
        ga    = g1 ? a1 : a0;
        legal = (ga[31:12] == 20'h00008) && !(g1 && w1);
        chk("p0_gnt", bus.p0_gnt_o, g0);
        chk("p1_gnt", bus.p1_gnt_o, g1);
        chk("one_gnt", bus.p0_gnt_o && bus.p1_gnt_o, 1'b0);
        chk("rom_en", bus.rom_en_o, (g0 || g1) && legal);
        if ((g0 || g1) && legal) chk("rom_addr", bus.rom_addr_o, ga[11:0]);
        if (g0 || g1)
            sb.push_back('{port: g1, err: !legal, data: legal ? rom_word(ga[11:2]) : 32'h0});

        @(posedge clk);
        #1;
        if (r) rr_m = 1'b1;
        else if (g0 || g1) rr_m = g1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] ra0;
        logic [31:0] ra1;

        // Reset with requests pending: no grants, no responses.
        cycle(1'b1, 1'b1, 32'h8000, 1'b1, 1'b0, 32'h8004);
        cycle(1'b1, 1'b1, 32'h8000, 1'b1, 1'b0, 32'h8004);

        // Single P0 read of word 0.
        cycle(1'b0, 1'b1, 32'h8000, 1'b0, 1'b0, 32'h0);
        idle();

        // Continuous dual request: alternating grants.
        for (int i = 0; i < 6; i++)
            cycle(1'b0, 1'b1, 32'h8000 + 32'(i * 16), 1'b1, 1'b0, 32'h8800 + 32'(i * 8));
        idle();

        // P1 write is refused with an error.
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8004);
        idle();

        // P0 outside the window.
        cycle(1'b0, 1'b1, 32'h9000, 1'b0, 1'b0, 32'h0);
        idle();

        // Unaligned and top-of-window reads.
        cycle(1'b0, 1'b1, 32'h8007, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8FFE);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h7FFC);
        idle();

        // Reset right after a grant discards the response; tie then favours P0.
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8010);
        cycle(1'b0, 1'b1, 32'h8020, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h8020, 1'b1, 1'b0, 32'h8030);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h8040, 1'b1, 1'b0, 32'h8044);
        cycle(1'b0, 1'b1, 32'h8040, 1'b1, 1'b0, 32'h8044);
        idle();

        // Random traffic.
        for (int i = 0; i < 10000; i++) begin
            ra0 = ($urandom_range(0, 9) < 8) ? (32'h8000 | 32'($urandom_range(0, 4095))) : 32'($urandom);
            ra1 = ($urandom_range(0, 9) < 8) ? (32'h8000 | 32'($urandom_range(0, 4095))) : 32'($urandom);
            cycle(1'b0, 1'($urandom_range(0, 1)), ra0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), ra1);
        end
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
